// File: rtl/beta_operand_fetch.sv
// rtl/beta_operand_fetch.sv - Beta register-read stage: decode, register file read, forwarding, load-use stall
//
// Sits between fetch and execute. Decodes the source fields of the incoming
// instruction, drives the register file read addresses, selects operand
// values and holds them in a valid/ready pipeline register feeding execute.
//
// Build option: BYPASS_EN
//   defined   - operands are forwarded from EX (non-load), MEM and WB; only a
//               load in EX feeding a used source causes a stall.
//   undefined - operands come only from the register file; any used source
//               with a pending EX/MEM/WB write stalls until the write retires.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kill the in-flight instruction
//   in_valid/in_ready        fetch handshake; in_pc, in_instr payload
//   rf_ra1/rf_ra2            register file read addresses (combinational)
//   rf_rd1/rf_rd2            register file read data (combinational return)
//   ex_*/mem_*/wb_*          pending register writes in later stages
//   out_valid/out_ready      execute handshake
//   out_pc, out_instr        registered instruction
//   out_a, out_b, out_lit    operand A (Ra), operand B (Rb or Rc for ST),
//                            sign-extended 16-bit literal
module beta_operand_fetch #(
  parameter int         XLEN   = 32,
  parameter logic [5:0] ST_OPC = 6'h19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rf_ra1,
  output logic [4:0]      rf_ra2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            ex_valid,
  input  logic            ex_wen,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_wa,
  input  logic [XLEN-1:0] ex_wd,
  input  logic            mem_valid,
  input  logic            mem_wen,
  input  logic [4:0]      mem_wa,
  input  logic [XLEN-1:0] mem_wd,
  input  logic            wb_valid,
  input  logic            wb_wen,
  input  logic [4:0]      wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_lit
);

  logic [5:0]      opc;
  logic [4:0]      rc;
  logic [4:0]      ra;
  logic [4:0]      rb;
  logic [4:0]      src_b;
  logic            is_st;
  logic            a_live;
  logic            b_live;
  logic            stall;
  logic            advance;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] lit;

  assign opc   = in_instr[31:26];
  assign rc    = in_instr[25:21];
  assign ra    = in_instr[20:16];
  assign rb    = in_instr[15:11];
  assign is_st = (opc == ST_OPC);

  // Stores read their data register through the rc field.
  assign src_b  = is_st ? rc : rb;
  assign rf_ra1 = ra;
  assign rf_ra2 = src_b;

  // R31 reads as zero, so it never needs a hazard check or a forward.
  assign a_live = (ra != 5'd31);
  assign b_live = ((opc[5:4] == 2'b10) || is_st) && (src_b != 5'd31);

  assign lit = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};

  function automatic logic hit(input logic v, input logic w, input logic [4:0] wa,
                               input logic [4:0] src);
    return v && w && (wa == src);
  endfunction

`ifdef BYPASS_EN
  logic ex_fwd;

  // A load in EX has no data yet; it is excluded from forwarding and stalls.
  assign ex_fwd = ex_valid && ex_wen && !ex_is_load;

  function automatic logic [XLEN-1:0] pick(input logic [4:0] src, input logic [XLEN-1:0] rf);
    if (src == 5'd31)                          return '0;
    else if (hit(ex_fwd, 1'b1, ex_wa, src))    return ex_wd;
    else if (hit(mem_valid, mem_wen, mem_wa, src)) return mem_wd;
    else if (hit(wb_valid, wb_wen, wb_wa, src))    return wb_wd;
    else                                       return rf;
  endfunction

  assign op_a  = pick(ra, rf_rd1);
  assign op_b  = pick(src_b, rf_rd2);
  assign stall = in_valid &&
                 ((a_live && hit(ex_valid, ex_wen && ex_is_load, ex_wa, ra)) ||
                  (b_live && hit(ex_valid, ex_wen && ex_is_load, ex_wa, src_b)));
`else
  logic unused_fwd_data;

  // Without bypass paths the write data and load flag are not needed.
  assign unused_fwd_data = ^{ex_wd, mem_wd, wb_wd, ex_is_load};

  function automatic logic pending(input logic [4:0] src);
    return hit(ex_valid, ex_wen, ex_wa, src) ||
           hit(mem_valid, mem_wen, mem_wa, src) ||
           hit(wb_valid, wb_wen, wb_wa, src);
  endfunction

  assign op_a  = (ra == 5'd31) ? '0 : rf_rd1;
  assign op_b  = (src_b == 5'd31) ? '0 : rf_rd2;
  assign stall = in_valid && ((a_live && pending(ra)) || (b_live && pending(src_b)));
`endif

  assign advance  = !out_valid || out_ready;
  assign in_ready = flush || (!stall && advance);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_lit   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      // A stalled instruction leaves a bubble and stays on the input.
      out_valid <= in_valid && !stall;
      if (in_valid && !stall) begin
        out_pc    <= in_pc;
        out_instr <= in_instr;
        out_a     <= op_a;
        out_b     <= op_b;
        out_lit   <= lit;
      end
    end
  end

endmodule
